// File: rtl/spi_controller.sv
// SPI mode-0 write/read command master: shifts one 16-bit frame {rw, addr, wdata}
// MSB first, then holds nCS high for an inter-frame gap before pulsing done.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  output logic       busy,
  output logic       done
);

  // Handshake: start is sampled only in IDLE with busy low. busy stays high
  // through the done cycle, so the earliest next accept is the cycle after done.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      SCLK    <= 1'b0;
      COPI    <= 1'b0;
      nCS     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          if (start && !busy) begin
            shift <= {rw, addr, wdata};
            COPI  <= rw;
            nCS   <= 1'b0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= 1'b1;
            state   <= SCLK_HI;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SCLK_HI: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= 1'b0;
            if (bit_cnt == 4'd15) begin
              state <= HOLD;
            end else begin
              // Next bit is presented on the falling edge, a half period before the rise.
              shift   <= {shift[14:0], 1'b0};
              COPI    <= shift[14];
              bit_cnt <= bit_cnt + 4'd1;
              state   <= SCLK_LO;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SCLK_LO: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= 1'b1;
            state   <= SCLK_HI;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            nCS     <= 1'b1;
            COPI    <= 1'b0;
            state   <= GAP;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: frame contents, timing, start blocking,
// reset behaviour and a simple SPI register peripheral fed by the serial lines.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       SCLK, COPI, nCS, busy, done;

  int tests = 0;
  int fails = 0;

  spi_controller #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .SCLK(SCLK), .COPI(COPI), .nCS(nCS), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Line monitor and peripheral model, sampled on the falling clk edge.
  logic        prev_sclk = 1'b0;
  logic        prev_ncs  = 1'b1;
  logic [15:0] per_sh    = '0;
  logic [15:0] last_frame = '0;
  int          per_bits  = 0;
  int          rise_cnt  = 0;
  int          low_cnt   = 0;
  int          done_cnt  = 0;
  int          high_run  = 0;
  int          last_high = 0;
  logic [7:0]  regs [0:127];

  initial for (int i = 0; i < 128; i++) regs[i] = 8'h00;

  always @(negedge clk) begin
    prev_sclk <= SCLK;
    prev_ncs  <= nCS;
    if (done) done_cnt <= done_cnt + 1;
    if (!nCS) low_cnt <= low_cnt + 1;
    if (nCS) begin
      high_run <= high_run + 1;
    end else begin
      if (high_run != 0) last_high <= high_run;
      high_run <= 0;
    end
    if (prev_ncs && !nCS) per_bits <= 0;
    if (SCLK && !prev_sclk && !nCS) begin
      per_sh   <= {per_sh[14:0], COPI};
      per_bits <= per_bits + 1;
      rise_cnt <= rise_cnt + 1;
    end
    if (nCS && !prev_ncs && per_bits == 16) begin
      last_frame <= per_sh;
      if (per_sh[15]) regs[per_sh[14:8]] <= per_sh[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one frame, scramble the inputs after acceptance, wait for done.
  task automatic do_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                          output int lat);
    @(negedge clk);
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rw = ~r; addr = ~a; wdata = 8'($urandom_range(0, 255));
    lat = 1;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic frame_checks(input string tag, input logic r, input logic [6:0] a,
                              input logic [7:0] d);
    int lat, b_rise, b_low, b_done;
    b_rise = rise_cnt; b_low = low_cnt; b_done = done_cnt;
    do_frame(r, a, d, lat);
    check({tag, "_latency"}, lat, 141);
    check({tag, "_bits"}, last_frame, {r, a, d});
    check({tag, "_rises"}, rise_cnt - b_rise, 16);
    check({tag, "_ncs_low"}, low_cnt - b_low, 132);
    check({tag, "_done_cnt"}, done_cnt - b_done, 1);
  endtask

  initial begin
    int lat, b_rise, b_done, guard;
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ncs", nCS, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_copi", COPI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic write and read frames with exact timing.
    frame_checks("wr_04_80", 1'b1, 7'h04, 8'h80);
    check("wr_04_80_word", last_frame, 16'h8480);
    frame_checks("rd_7f_00", 1'b0, 7'h7F, 8'h00);
    check("rd_7f_00_word", last_frame, 16'h7F00);
    check("rd_no_write", regs[7'h7F], 8'h00);

    // Start re-pulsed while busy and on the done cycle, then accepted right after.
    b_rise = rise_cnt; b_done = done_cnt;
    @(negedge clk);
    rw = 1'b1; addr = 7'h2A; wdata = 8'h5C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      start = (lat == 10 || lat == 100);
      if (start) begin
        rw = 1'b0; addr = 7'h33; wdata = 8'h99;
      end
      @(negedge clk);
      lat++;
    end
    rw = 1'b1; addr = 7'h05; wdata = 8'hA5; start = 1'b1;
    @(negedge clk);
    check("blk_latency", lat, 141);
    check("blk_done_cycle_ignored_ncs", nCS, 1);
    check("blk_done_low", done, 0);
    @(negedge clk);
    start = 1'b0;
    check("blk_accept_after_done_ncs", nCS, 0);
    check("blk_busy_after_accept", busy, 1);
    @(negedge clk);
    check("blk_frame_a_bits", last_frame, 16'hAA5C);
    check("blk_rises_a", rise_cnt - b_rise, 16);
    check("blk_done_once", done_cnt - b_done, 1);
    check("blk_ncs_high_gap", last_high, 10);
    lat = 0;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    check("blk_frame_b_bits", last_frame, 16'h85A5);

    // Reset after the 7th SCLK rise aborts the frame silently.
    b_rise = rise_cnt;
    @(negedge clk);
    rw = 1'b1; addr = 7'h11; wdata = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (rise_cnt - b_rise < 7 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_7", rise_cnt - b_rise, 7);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ncs", nCS, 1);
    check("abort_sclk", SCLK, 0);
    check("abort_busy", busy, 0);
    check("abort_copi", COPI, 0);
    rst = 1'b0;
    b_rise = rise_cnt; b_done = done_cnt;
    repeat (300) @(negedge clk);
    check("abort_no_done", done_cnt - b_done, 0);
    check("abort_no_rises", rise_cnt - b_rise, 0);
    check("abort_no_write", regs[7'h11], 8'h00);
    frame_checks("after_abort", 1'b1, 7'h11, 8'h3C);
    check("after_abort_word", last_frame, 16'h913C);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_start_ncs", nCS, 1);
    check("rst_start_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_idle_ncs", nCS, 1);
    check("rst_start_idle_busy", busy, 0);

    // Program the peripheral register file.
    for (int i = 0; i < 4; i++) do_frame(1'b1, 7'(i), 8'hFF, lat);
    do_frame(1'b1, 7'h04, 8'h80, lat);
    check("per_reg0", regs[0], 8'hFF);
    check("per_reg1", regs[1], 8'hFF);
    check("per_reg2", regs[2], 8'hFF);
    check("per_reg3", regs[3], 8'hFF);
    check("per_reg4", regs[4], 8'h80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 8: minimum clk cycles nCS stays high between frames; legal range 6..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request one frame; accepted only while busy=0.
REQ-006 The block SHALL have port rw, input, 1 bit: frame bit 15; 1=write, 0=read command.
REQ-007 The block SHALL have port addr, input, 7 bits: frame bits 14:8.
REQ-008 The block SHALL have port wdata, input, 8 bits: frame bits 7:0.
REQ-009 The block SHALL have port SCLK, output, 1 bit: serial clock, idle low (SPI mode 0).
REQ-010 The block SHALL have port COPI, output, 1 bit: serial data to the peripheral, MSB first.
REQ-011 The block SHALL have port nCS, output, 1 bit: active-low chip select.
REQ-012 The block SHALL have port busy, output, 1 bit: frame or inter-frame gap in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a frame, including its gap, completes.

Function
REQ-014 SCLK, COPI, nCS, busy and done SHALL all be driven directly from flops; no combinational path to any output.
REQ-015 States SHALL be IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP, with one divider counter (0..CLK_DIV-1 or 0..GAP_CYCLES-1) and a 4-bit bit counter.
REQ-016 In IDLE: nCS=1, SCLK=0, COPI=0, busy=0; start=1 SHALL latch {rw,addr,wdata} into a 16-bit shift register and move to SETUP.
REQ-017 On the cycle after start is accepted: nCS=0, COPI=frame[15], busy=1.
REQ-018 SETUP SHALL hold SCLK=0 for CLK_DIV cycles, then enter SCLK_HI.
REQ-019 SCLK_HI SHALL drive SCLK=1 for CLK_DIV cycles, with COPI stable for the whole high phase.
REQ-020 At the end of SCLK_HI, if bits remain: enter SCLK_LO, SCLK=0 and COPI=next bit on the same cycle; after the 16th high phase: enter HOLD.
REQ-021 SCLK_LO SHALL hold SCLK=0 for CLK_DIV cycles, then enter SCLK_HI.
REQ-022 HOLD SHALL keep nCS=0, SCLK=0 for CLK_DIV cycles, then drive nCS=1 and COPI=0 and enter GAP.
REQ-023 GAP SHALL keep nCS=1, busy=1 for GAP_CYCLES cycles, then return to IDLE with done=1 for exactly that one cycle.
REQ-024 Exactly 16 SCLK rising edges SHALL occur per frame, and nCS low time SHALL be exactly 33*CLK_DIV cycles.
REQ-025 Total latency from start-accept cycle to done SHALL be 1+33*CLK_DIV+GAP_CYCLES cycles.
REQ-026 start while busy=1, including the done cycle, SHALL be ignored; start on the done cycle is not accepted, and start is accepted from the cycle after done.
REQ-027 rw/addr/wdata changes after acceptance SHALL NOT affect the frame in flight.
REQ-028 A read frame (rw=0) SHALL be shifted identically to a write; the block does not sample any return data.

Reset
REQ-029 rst=1 SHALL force, on the next clk edge: state=IDLE, nCS=1, SCLK=0, COPI=0, busy=0, done=0, counters=0, shift register=0.
REQ-030 rst asserted mid-frame SHALL abort the frame with no done pulse and no further SCLK edges.
REQ-031 rst and start asserted in the same cycle: reset wins and the start is dropped.

Verification
REQ-032 Scenario: CLK_DIV=4, GAP_CYCLES=8, start with rw=1, addr=0x04, wdata=0x80 -> COPI sampled at 16 SCLK rises = 1000_0100_1000_0000, nCS low 132 cycles, done 141 cycles after the accept cycle.
REQ-033 Scenario: start with rw=0, addr=0x7F, wdata=0x00 -> bits 0111_1111_0000_0000, 16 SCLK rises, done pulses once.
REQ-034 Scenario: start re-pulsed at cycles 10, 100 and on the done cycle -> no extra frame and frame bits unchanged; start the cycle after done -> new frame with nCS falling one cycle later and nCS high for >=GAP_CYCLES+1 cycles between frames.
REQ-035 Scenario: rst=1 after the 7th SCLK rise -> next cycle nCS=1, SCLK=0, busy=0, no done; subsequent start yields a full correct frame.
REQ-036 Scenario: rst=1 and start=1 in the same cycle -> stays IDLE, nCS=1, busy=0.
REQ-037 Scenario: the block drives the team's SPI peripheral with writes 0xFF to addr 0..3 and 0x80 to addr 4 -> peripheral registers read 0xFF,0xFF,0xFF,0xFF,0x80.
